// File: rtl/xmem_loader_pkg.sv
// xmem_loader_pkg: shared xmem port widths and loader FSM encoding.
package xmem_loader_pkg;
   localparam int MEM_ADDR_W = 10;
   localparam int MEM_DATA_W = 32;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST, S_DONE} state_t;
endpackage

// File: rtl/xmem_loader_agen.sv
// xmem_loader_agen: address accumulator and word counter for the loader.
module xmem_loader_agen import xmem_loader_pkg::*; #(
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [ADDR_W-1:0] cfg_incr,
   input  logic [ADDR_W:0]   cfg_len,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   logic [ADDR_W-1:0] addr_q, addr_d, incr_q, incr_d;
   logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d, idx_n;
   assign idx_n = idx_q + 1'b1;
   assign addr  = addr_q;
   // last flags that the word being accepted now is the final one
   assign last  = idx_n == len_q;
   always_comb begin
      addr_d = load ? cfg_addr : step ? addr_q + incr_q : addr_q;
      incr_d = load ? cfg_incr : incr_q;
      len_d  = load ? cfg_len : len_q;
      idx_d  = load ? '0 : step ? idx_n : idx_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         incr_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         addr_q <= addr_d;
         incr_q <= incr_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end
endmodule

// File: rtl/xmem_loader.sv
// xmem_loader: streams words into an xmem at strided addresses.
module xmem_loader import xmem_loader_pkg::*; #(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [ADDR_W-1:0] cfg_incr,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count
);
   state_t            state_q, state_d;
   logic              mem_valid_q, mem_valid_d, busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, gen_addr;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              accept, load, go, gen_last;
   assign s_ready = state_q == S_LOAD;
   assign accept  = s_ready && s_valid;
   assign go      = state_q == S_IDLE && start;
   assign load    = go && cfg_len != '0;
   xmem_loader_agen #(.ADDR_W(ADDR_W)) u_agen (
      .clk(clk), .rst(rst), .load(load), .step(accept),
      .cfg_addr(cfg_addr), .cfg_incr(cfg_incr), .cfg_len(cfg_len),
      .addr(gen_addr), .last(gen_last)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = !start ? S_IDLE : load ? S_LOAD : S_DONE;
         S_LOAD: state_d = abort ? S_IDLE : (accept && gen_last) ? S_LAST : S_LOAD;
         S_LAST: state_d = abort ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
      // an accept coinciding with abort is dropped rather than written
      mem_valid_d = accept && !abort;
      mem_addr_d  = accept ? gen_addr : mem_addr_q;
      mem_wdata_d = accept ? s_data : mem_wdata_q;
      count_d     = go ? '0 : count_q + {{ADDR_W{1'b0}}, mem_valid_q};
      busy_d      = state_d != S_IDLE;
      done_d      = state_d == S_DONE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end
   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
endmodule

// File: tb/tb_xmem_loader.sv
// tb_xmem_loader: directed scoreboard bench for xmem_loader.
module tb_xmem_loader;
   typedef struct {logic [9:0] a; logic [31:0] d; int c;} wr_t;
   typedef struct {logic [10:0] n; int c;} dn_t;
   logic        clk = 0, rst = 0, start = 0, abort = 0, s_valid = 0;
   logic [9:0]  cfg_addr = 0, cfg_incr = 0;
   logic [10:0] cfg_len = 0;
   logic [31:0] s_data = 0;
   logic        s_ready, mem_valid, mem_we, busy, done;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [10:0] count;
   int          checks = 0, errors = 0, cyc = 0;
   wr_t         wq[$];
   dn_t         dq[$];
   xmem_loader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_addr(cfg_addr), .cfg_incr(cfg_incr), .cfg_len(cfg_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .count(count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst) begin
         if (mem_valid) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(e.a));
               chk("wr_data", mem_wdata, e.d);
               chk("wr_cycle", cyc, e.c);
               chk("wr_we", 32'(mem_we), 1);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               dn_t e;
               e = dq.pop_front();
               chk("done_count", 32'(count), 32'(e.n));
               chk("done_cycle", cyc, e.c);
            end
         end
      end
   end
   task automatic start_load(input logic [9:0] a, input logic [9:0] inc, input logic [10:0] len);
      @(negedge clk);
      cfg_addr = a; cfg_incr = inc; cfg_len = len; start = 1;
      if (len == 0) dq.push_back('{11'd0, cyc + 1});
      @(posedge clk);
      #1 start = 0;
   endtask
   task automatic send_word(input logic [31:0] d, input logic [9:0] a, input bit last, input logic [10:0] n);
      int w = 0;
      @(negedge clk);
      s_valid = 1; s_data = d;
      while (!s_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!s_ready) chk("ready_timeout", 0, 1);
      else begin
         wq.push_back('{a, d, cyc + 1});
         if (last) dq.push_back('{n, cyc + 2});
      end
      @(posedge clk);
      #1 s_valid = 0;
   endtask
   task automatic wait_idle(input string nm);
      int w = 0;
      @(negedge clk);
      while (busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({nm, "_idle"}, 32'(busy), 0);
      chk({nm, "_drained"}, wq.size() + dq.size(), 0);
   endtask
   task automatic check_zero(input string nm);
      chk({nm, "_s_ready"}, 32'(s_ready), 0);
      chk({nm, "_mem_valid"}, 32'(mem_valid), 0);
      chk({nm, "_mem_we"}, 32'(mem_we), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_count"}, 32'(count), 0);
      chk({nm, "_addr"}, 32'(mem_addr), 0);
      chk({nm, "_wdata"}, mem_wdata, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      #1 check_zero("reset");
      #20 rst = 1;
      start_load(10'd5, 10'd1, 11'd4);
      send_word(32'hA0, 10'd5, 0, 0);
      send_word(32'hA1, 10'd6, 0, 0);
      send_word(32'hA2, 10'd7, 0, 0);
      send_word(32'hA3, 10'd8, 1, 11'd4);
      wait_idle("seq");
      start_load(10'd1020, 10'd3, 11'd3);
      send_word(32'h11, 10'd1020, 0, 0);
      send_word(32'h22, 10'd1023, 0, 0);
      send_word(32'h33, 10'd2, 1, 11'd3);
      wait_idle("wrap");
      start_load(10'd40, 10'd2, 11'd4);
      send_word(32'hB0, 10'd40, 0, 0);
      @(posedge clk);
      send_word(32'hB1, 10'd42, 0, 0);
      @(posedge clk);
      send_word(32'hB2, 10'd44, 0, 0);
      @(posedge clk);
      send_word(32'hB3, 10'd46, 1, 11'd4);
      wait_idle("bubble");
      start_load(10'd9, 10'd1, 11'd0);
      wait_idle("zero_len");
      chk("zero_len_count", 32'(count), 0);
      start_load(10'd0, 10'd1, 11'd8);
      send_word(32'hC0, 10'd0, 0, 0);
      send_word(32'hC1, 10'd1, 0, 0);
      @(negedge clk);
      abort = 1;
      @(posedge clk);
      #1 abort = 0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_count", 32'(count), 2);
      repeat (3) @(posedge clk);
      start_load(10'd50, 10'd1, 11'd1);
      send_word(32'hD0, 10'd50, 1, 11'd1);
      wait_idle("post_abort");
      start_load(10'd100, 10'd1, 11'd4);
      send_word(32'hE0, 10'd100, 0, 0);
      start_load(10'd200, 10'd1, 11'd4);
      send_word(32'hE1, 10'd101, 0, 0);
      @(negedge clk);
      #2 rst = 0;
      #1 check_zero("mid_reset");
      wq.delete();
      dq.delete();
      @(negedge clk);
      rst = 1;
      start_load(10'd300, 10'd4, 11'd2);
      send_word(32'hF0, 10'd300, 0, 0);
      send_word(32'hF1, 10'd304, 1, 11'd2);
      wait_idle("after_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
